// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction fetch memory: the load/run state,
// the NOP word returned on faulting fetches, and the default geometry.
package instr_mem_pkg;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 32;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one write port, one synchronous read port, no reset so the
// contents survive both reset and reload sessions.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read data only moves on an enabled read, which keeps a stalled word stable.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch_memory.sv
// Loadable instruction memory: a LOAD phase streams words in sequentially, a RUN phase
// serves byte-addressed fetches with one cycle of latency and a valid/ready handshake.
module instruction_fetch_memory
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  LoadStart,
    input  logic                  LoadEn,
    input  logic [DATA_WIDTH-1:0] LoadData,
    input  logic                  LoadDone,
    output logic                  LoadWrap,
    input  logic                  FetchReq,
    input  logic [31:0]           Address,
    output logic                  FetchReady,
    output logic                  InstrValid,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  Fault,
    input  logic                  InstrReady
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  wrap_q, wrap_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;

    logic                  accept;
    logic                  bad_addr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;

    assign FetchReady = (state_q == RUN) && (!valid_q || InstrReady);
    assign accept     = FetchReq && FetchReady;
    assign raddr      = Address[ADDR_WIDTH+1:2];

    // Any set bit above the word index means the fetch lies outside the array.
    assign bad_addr = (|Address[1:0]) || (|(Address >> (ADDR_WIDTH + 2)));

    assign mem_we = (state_q == LOAD) && LoadEn && !LoadStart;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrap_d  = wrap_q;
        valid_d = valid_q;
        fault_d = fault_q;

        unique case (state_q)
            LOAD: begin
                if (LoadStart) begin
                    ptr_d  = '0;
                    wrap_d = 1'b0;
                end else if (LoadEn) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        wrap_d = 1'b1;
                    end
                end
                if (LoadDone) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (LoadStart) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
        endcase

        // Re-entering LOAD drops whatever word was waiting for the consumer.
        if ((state_q == RUN) && LoadStart) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            fault_d = bad_addr;
        end else if (InstrReady) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    instr_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (ptr_q),
        .wdata_i (LoadData),
        .re_i    (accept),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign LoadWrap    = wrap_q;
    assign InstrValid  = valid_q;
    assign Fault       = valid_q && fault_q;
    assign Instruction = (valid_q && !fault_q) ? rdata : DATA_WIDTH'(NOP);

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Directed bench for instruction_fetch_memory: a vector table for fetch behaviour plus
// hand-written load, reload, reset and pointer-wrap sequences.
module tb_instruction_fetch_memory;

    logic        clk;
    logic        reset_n;
    logic        LoadStart, LoadEn, LoadDone, FetchReq, InstrReady;
    logic [31:0] LoadData, Address;
    logic        LoadWrap, FetchReady, InstrValid, Fault;
    logic [31:0] Instruction;

    logic        w_LoadStart, w_LoadEn, w_LoadDone, w_FetchReq, w_InstrReady;
    logic [31:0] w_LoadData, w_Address;
    logic        w_LoadWrap, w_FetchReady, w_InstrValid, w_Fault;
    logic [31:0] w_Instruction;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .LoadStart(LoadStart), .LoadEn(LoadEn),
        .LoadData(LoadData), .LoadDone(LoadDone), .LoadWrap(LoadWrap), .FetchReq(FetchReq),
        .Address(Address), .FetchReady(FetchReady), .InstrValid(InstrValid),
        .Instruction(Instruction), .Fault(Fault), .InstrReady(InstrReady)
    );

    instruction_fetch_memory #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut_w (
        .clk(clk), .reset_n(reset_n), .LoadStart(w_LoadStart), .LoadEn(w_LoadEn),
        .LoadData(w_LoadData), .LoadDone(w_LoadDone), .LoadWrap(w_LoadWrap),
        .FetchReq(w_FetchReq), .Address(w_Address), .FetchReady(w_FetchReady),
        .InstrValid(w_InstrValid), .Instruction(w_Instruction), .Fault(w_Fault),
        .InstrReady(w_InstrReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        rdy;
        logic        exp_fready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] words[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input logic req, input logic [31:0] addr, input logic rdy,
                                    input logic fr, input logic v, input logic [31:0] ins,
                                    input logic f);
        vec_t t;
        t.req = req; t.addr = addr; t.rdy = rdy;
        t.exp_fready = fr; t.exp_valid = v; t.exp_instr = ins; t.exp_fault = f;
        vecs.push_back(t);
    endfunction

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] exp_instr,
                             input logic exp_fault, input string name);
        FetchReq = 1'b1; Address = addr; InstrReady = 1'b1;
        tick();
        FetchReq = 1'b0;
        check({name, " valid"}, {31'b0, InstrValid}, 32'd1);
        check({name, " instr"}, Instruction, exp_instr);
        check({name, " fault"}, {31'b0, Fault}, {31'b0, exp_fault});
    endtask

    task automatic w_fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                           input logic exp_fault, input string name);
        w_FetchReq = 1'b1; w_Address = addr; w_InstrReady = 1'b1;
        tick();
        w_FetchReq = 1'b0;
        check({name, " valid"}, {31'b0, w_InstrValid}, 32'd1);
        check({name, " instr"}, w_Instruction, exp_instr);
        check({name, " fault"}, {31'b0, w_Fault}, {31'b0, exp_fault});
    endtask

    initial begin
        words = '{32'h20040004, 32'h0c000003, 32'h20050005, 32'h00851020, 32'h00a63022,
                  32'h10400002, 32'h8c070000, 32'hac070004, 32'h00e74020, 32'h2108ffff,
                  32'h1500fffe, 32'h00000000, 32'h3c091234, 32'h35295678, 32'h01295025,
                  32'h000a5840, 32'h08000000, 32'h03e00008};

        // Streaming 0x0..0x44 with ready held; the first row is the boot fetch.
        for (int i = 0; i < 18; i++) add_vec(1, 32'(4 * i), 1, 1, 1, words[i], 0);
        add_vec(0, 32'h0, 1, 1, 0, 32'h0, 0);
        add_vec(1, 32'h6, 1, 1, 1, 32'h0, 1);
        add_vec(0, 32'h0, 0, 0, 1, 32'h0, 1);
        add_vec(1, 32'h400, 1, 1, 1, 32'h0, 1);
        add_vec(1, 32'h44, 1, 1, 1, words[17], 0);
        add_vec(1, 32'h5, 1, 1, 1, 32'h0, 1);
        add_vec(1, 32'h0100_0000, 1, 1, 1, 32'h0, 1);
        // Stall: word at 0x4 held for three cycles, then the next fetch goes through.
        add_vec(1, 32'h4, 1, 1, 1, words[1], 0);
        for (int i = 0; i < 3; i++) add_vec(1, 32'h8, 0, 0, 1, words[1], 0);
        add_vec(1, 32'h8, 1, 1, 1, words[2], 0);
        add_vec(0, 32'h0, 0, 0, 1, words[2], 0);
        add_vec(0, 32'h0, 1, 1, 0, 32'h0, 0);

        reset_n = 1'b0;
        {LoadStart, LoadEn, LoadDone, FetchReq, InstrReady} = '0;
        LoadData = '0; Address = '0;
        {w_LoadStart, w_LoadEn, w_LoadDone, w_FetchReq, w_InstrReady} = '0;
        w_LoadData = '0; w_Address = '0;
        #3;
        check("reset valid", {31'b0, InstrValid}, 32'd0);
        check("reset instr", Instruction, 32'h0);
        check("reset fault", {31'b0, Fault}, 32'd0);
        check("reset fready", {31'b0, FetchReady}, 32'd0);
        check("reset wrap", {31'b0, LoadWrap}, 32'd0);
        check("reset w fready", {31'b0, w_FetchReady}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;

        // Load 18 words; the final write coincides with LoadDone.
        LoadStart = 1'b1; tick(); LoadStart = 1'b0;
        for (int i = 0; i < 18; i++) begin
            LoadEn = 1'b1; LoadData = words[i]; LoadDone = (i == 17);
            #2;
            check("load fready", {31'b0, FetchReady}, 32'd0);
            tick();
        end
        LoadEn = 1'b0; LoadDone = 1'b0;
        check("load no wrap", {31'b0, LoadWrap}, 32'd0);

        foreach (vecs[i]) begin
            FetchReq = vecs[i].req; Address = vecs[i].addr; InstrReady = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d fready", i), {31'b0, FetchReady}, {31'b0, vecs[i].exp_fready});
            tick();
            check($sformatf("vec%0d valid", i), {31'b0, InstrValid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d instr", i), Instruction, vecs[i].exp_instr);
            check($sformatf("vec%0d fault", i), {31'b0, Fault}, {31'b0, vecs[i].exp_fault});
        end
        FetchReq = 1'b0;

        // LoadEn in RUN must not write.
        LoadEn = 1'b1; LoadData = 32'hdeadbeef; tick(); LoadEn = 1'b0;
        fetch_one(32'h0, words[0], 1'b0, "run loaden ignored");

        // LoadStart in RUN drops the pending word; fetches in LOAD are ignored.
        InstrReady = 1'b0; LoadStart = 1'b1; tick(); LoadStart = 1'b0;
        check("reload drops valid", {31'b0, InstrValid}, 32'd0);
        #2;
        check("reload fready", {31'b0, FetchReady}, 32'd0);
        FetchReq = 1'b1; Address = 32'h0; InstrReady = 1'b1; tick(); FetchReq = 1'b0;
        check("load fetch ignored", {31'b0, InstrValid}, 32'd0);
        LoadDone = 1'b1; tick(); LoadDone = 1'b0;
        fetch_one(32'h8, words[2], 1'b0, "mem persists reload");

        // Asynchronous reset while a word is pending.
        InstrReady = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset valid", {31'b0, InstrValid}, 32'd0);
        check("midreset instr", Instruction, 32'h0);
        check("midreset fault", {31'b0, Fault}, 32'd0);
        check("midreset fready", {31'b0, FetchReady}, 32'd0);
        tick();
        reset_n = 1'b1;
        InstrReady = 1'b1;
        #2;
        check("post reset in load", {31'b0, FetchReady}, 32'd0);
        tick();
        LoadDone = 1'b1; tick(); LoadDone = 1'b0;
        fetch_one(32'h0, words[0], 1'b0, "mem persists reset");
        fetch_one(32'h44, words[17], 1'b0, "mem persists reset last");

        // Pointer wrap on the four-word instance.
        w_LoadStart = 1'b1; tick(); w_LoadStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w_LoadEn = 1'b1; w_LoadData = 32'hA000_0000 + 32'(i);
            tick();
            check($sformatf("wrap flag after %0d", i + 1), {31'b0, w_LoadWrap},
                  (i >= 3) ? 32'd1 : 32'd0);
        end
        w_LoadEn = 1'b0;
        w_LoadDone = 1'b1; tick(); w_LoadDone = 1'b0;
        w_fetch(32'h0, 32'hA000_0004, 1'b0, "wrap mem0 is E");
        w_fetch(32'h4, 32'hA000_0001, 1'b0, "wrap mem1 is B");
        w_fetch(32'h10, 32'h0, 1'b1, "wrap out of range");
        check("wrap sticky in run", {31'b0, w_LoadWrap}, 32'd1);
        w_LoadStart = 1'b1; tick(); w_LoadStart = 1'b0;
        check("wrap cleared", {31'b0, w_LoadWrap}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
